// File: rtl/rng_check_pkg.sv
// rng_check_pkg: shared sizes and state encoding for the RNG duplicate checker
package rng_check_pkg;
  localparam int MAX_LOG2 = 19;
  localparam int WORD_W = 32;
  localparam int BIT_W = 5;
  localparam int DEPTH = 2 ** (MAX_LOG2 - BIT_W);
  localparam int CNT_W = 20;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/rng_check_bitmap_ram.sv
// bitmap_ram: simple dual-port seen-value bitmap, 1-cycle synchronous read, no reset
module bitmap_ram
  import rng_check_pkg::*;
#(
  parameter int AW = MAX_LOG2 - BIT_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/rng_check.sv
// rng_check: consumes count generator values and flags any value seen twice in a run
module rng_check
  import rng_check_pkg::*;
#(
  parameter int MAX_LOG2 = rng_check_pkg::MAX_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    count,
  output logic                rng_next,
  input  logic                rng_ready,
  input  logic [MAX_LOG2-1:0] rng_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_W-1:0]    dup_count,
  output logic [MAX_LOG2-1:0] first_dup,
  output logic [CNT_W-1:0]    checked
);
  localparam int AW = MAX_LOG2 - BIT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic [AW-1:0] clr_addr, waddr;
  logic [CNT_W-1:0] count_q;
  logic drain_cnt, s1_v, fwd_v, we, dup, accept;
  logic [MAX_LOG2-1:0] s1_val;
  logic [WORD_W-1:0] rdata, fwd_data, cur, wdata;
  assign accept = rng_next && rng_ready;
  always_comb begin
    rng_next = state == RUN && checked != count_q;
    cur = fwd_v ? fwd_data : rdata;
    dup = s1_v && cur[s1_val[BIT_W-1:0]];
    we = state == CLEAR || s1_v;
    waddr = state == CLEAR ? clr_addr : s1_val[MAX_LOG2-1:BIT_W];
    wdata = state == CLEAR ? '0 : cur | (WORD_W'(1) << s1_val[BIT_W-1:0]);
  end
  bitmap_ram #(.AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(rng_data[MAX_LOG2-1:BIT_W]),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      dup_count <= '0;
      first_dup <= '0;
      checked <= '0;
      count_q <= '0;
      clr_addr <= '0;
      drain_cnt <= 1'b0;
      s1_v <= 1'b0;
      s1_val <= '0;
      fwd_v <= 1'b0;
      fwd_data <= '0;
    end else begin
      s1_v <= accept;
      s1_val <= rng_data;
      // S1 writes a word S0 reads this cycle; the RAM returns stale data, so bypass it
      fwd_v <= s1_v && s1_val[MAX_LOG2-1:BIT_W] == rng_data[MAX_LOG2-1:BIT_W];
      fwd_data <= wdata;
      if (accept) checked <= checked == CNT_MAX ? checked : checked + CNT_W'(1);
      if (dup) begin
        dup_count <= dup_count == CNT_MAX ? dup_count : dup_count + CNT_W'(1);
        if (!error) begin
          error <= 1'b1;
          first_dup <= s1_val;
        end
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= CLEAR;
          busy <= 1'b1;
          done <= 1'b0;
          count_q <= count;
          error <= 1'b0;
          dup_count <= '0;
          first_dup <= '0;
          checked <= '0;
          clr_addr <= '0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (&clr_addr) begin
            state <= count_q == '0 ? DRAIN : RUN;
            busy <= count_q != '0;
            drain_cnt <= 1'b0;
          end
        end
        RUN: if (accept && checked + CNT_W'(1) == count_q) begin
          state <= DRAIN;
          busy <= 1'b0;
          drain_cnt <= 1'b0;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rng_check.sv
// tb_rng_check: table vectors, randomized streams and reset/corner sequences against a set-based model
module tb_rng_check;
  localparam int M = 10;
  localparam int WORDS = 2 ** (M - 5);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rng_ready = 1'b0;
  logic rng_next, busy, done, error;
  logic [19:0] count = '0, dup_count, checked;
  logic [M-1:0] rng_data = '0, first_dup;
  int checks = 0, errors = 0;
  logic [M-1:0] stream[$];
  typedef struct {int v[4]; int cnt; int dups; int first; int err;} vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  rng_check #(.MAX_LOG2(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .rng_next(rng_next),
    .rng_ready(rng_ready), .rng_data(rng_data), .busy(busy), .done(done),
    .error(error), .dup_count(dup_count), .first_dup(first_dup), .checked(checked)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input string tag, input int cnt, input int pct, input int abort_at,
                     input int poke_at, output int cycles);
    int idx = 0, n = 0, viol = 0, limit, exp_d = 0, exp_first = 0, dpos = -1, rise = -1;
    bit acc;
    int acc_at[$];
    bit err_hist[$];
    bit seen[int];
    for (int i = 0; i < cnt; i++)
      if (seen.exists(int'(stream[i]))) begin
        if (dpos < 0) begin
          dpos = i;
          exp_first = int'(stream[i]);
        end
        exp_d++;
      end else seen[int'(stream[i])] = 1'b1;
    @(negedge clk);
    start = 1'b1;
    count = 20'(cnt);
    @(negedge clk);
    start = 1'b0;
    limit = WORDS + 20 * cnt + 100;
    while (!done && n < limit && idx != abort_at) begin
      if (rng_next && idx >= cnt) viol++;
      err_hist.push_back(error);
      start = (n == poke_at);
      rng_data = idx < stream.size() ? stream[idx] : '0;
      rng_ready = $urandom_range(99) < pct;
      acc = rng_next && rng_ready;
      if (acc) acc_at.push_back(n);
      @(negedge clk);
      n++;
      if (acc) idx++;
    end
    start = 1'b0;
    rng_ready = 1'b0;
    cycles = n;
    if (abort_at >= 0) begin
      chk({tag, " reached abort point"}, idx, abort_at);
      return;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " checked"}, checked, cnt);
    chk({tag, " dup_count"}, dup_count, exp_d);
    chk({tag, " first_dup"}, first_dup, exp_first);
    chk({tag, " error"}, error, exp_d > 0);
    chk({tag, " rng_next after count"}, viol, 0);
    if (dpos >= 0) begin
      foreach (err_hist[i]) if (err_hist[i] && rise < 0) rise = i;
      chk({tag, " dup latency"}, rise, acc_at[dpos] + 2);
    end
    repeat (4) @(negedge clk);
    chk({tag, " done held"}, done, 1);
    chk({tag, " checked held"}, checked, cnt);
  endtask
  initial begin
    int cyc;
    vecs[0] = '{'{5, 7, 5, 0}, 3, 1, 5, 1};
    vecs[1] = '{'{64, 64, 0, 0}, 2, 1, 64, 1};
    vecs[2] = '{'{1, 2, 3, 4}, 4, 0, 0, 0};
    vecs[3] = '{'{9, 9, 9, 9}, 4, 3, 9, 1};
    vecs[4] = '{'{32, 33, 32, 33}, 4, 2, 32, 1};
    vecs[5] = '{'{7, 3, 7, 0}, 2, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rng_next", rng_next, 0);
    chk("reset error", error, 0);
    chk("reset dup_count", dup_count, 0);
    chk("reset first_dup", first_dup, 0);
    chk("reset checked", checked, 0);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      stream.delete();
      for (int j = 0; j < 4; j++) stream.push_back(M'(vecs[i].v[j]));
      run($sformatf("vec%0d", i), vecs[i].cnt, 100, -1, -1, cyc);
      chk($sformatf("vec%0d table dup_count", i), dup_count, vecs[i].dups);
      chk($sformatf("vec%0d table first_dup", i), first_dup, vecs[i].first);
      chk($sformatf("vec%0d table error", i), error, vecs[i].err);
    end
    stream.delete();
    for (int i = 0; i < 1023; i++) stream.push_back(M'((i * 389) % 1024));
    run("perm", 1023, 100, -1, 5, cyc);
    stream.delete();
    for (int i = 0; i < 1000; i++) stream.push_back(M'(i));
    run("ready_rand", 1000, 60, -1, WORDS + 40, cyc);
    for (int k = 0; k < 3; k++) begin
      stream.delete();
      for (int i = 0; i < 300; i++) stream.push_back(M'($urandom_range(64 + 300 * k)));
      run($sformatf("rand%0d", k), 300, 75, -1, -1, cyc);
    end
    stream.delete();
    run("zero", 0, 100, -1, -1, cyc);
    chk("zero done latency", cyc, WORDS + 2);
    stream.delete();
    for (int i = 0; i < 200; i++) stream.push_back(M'(i));
    run("abort", 200, 100, 100, -1, cyc);
    chk("abort pre-reset checked", checked, 100);
    rst_n = 1'b0;
    #1;
    chk("midrun reset rng_next", rng_next, 0);
    chk("midrun reset busy", busy, 0);
    chk("midrun reset done", done, 0);
    chk("midrun reset checked", checked, 0);
    chk("midrun reset dup_count", dup_count, 0);
    chk("midrun reset error", error, 0);
    chk("midrun reset first_dup", first_dup, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stream.delete();
    for (int i = 0; i < 10; i++) stream.push_back(M'(i));
    run("after_reset", 10, 100, -1, -1, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
